// File: rtl/amber128_pkg.sv
// amber128 shared types and constants for the fetch/decode front end.
// Latency: n/a (package only).
// Backpressure: n/a.
package amber128_pkg;

    localparam int C_XLEN              = 128;
    localparam int AMBER128_SLOT_COUNT = 5;
    localparam int AMBER128_SLOT_W     = 24;
    localparam int AMBER128_SUB12_W    = 12;

    // Sequencer control state: EMPTY while no bundle is buffered, ISSUE while a head exists.
    typedef enum logic {
        SEQ_EMPTY = 1'b0,
        SEQ_ISSUE = 1'b1
    } amber128_seq_state_e;

    // One decoder-facing slot operation.
    typedef struct packed {
        logic                       valid;
        logic [63:0]                pc_word_addr;
        logic [2:0]                 slot_idx;
        logic                       sub12_idx;
        logic                       is_sub12;
        logic [AMBER128_SLOT_W-1:0] payload;
        logic                       last;
    } amber128_slot_op_s;

endpackage

// File: rtl/amber128_bundle_fifo.sv
// Bundle FIFO: DEPTH entries of {word address, bundle}, head exposed combinationally.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: caller gates i_push with count < DEPTH; i_flush empties it next cycle.
module amber128_bundle_fifo
    import amber128_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = 64 + C_XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_flush,
    input  logic                       i_push,
    input  logic [W-1:0]               i_dat,
    input  logic                       i_pop,
    output logic [W-1:0]               o_head,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr;
    logic [PTR_W-1:0] r_rd;
    logic [CNT_W-1:0] r_cnt;

    // Entry storage; contents need no reset since count qualifies them.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr] <= i_dat;
        end
    end

    // Pointers wrap modulo DEPTH; flush and reset return everything to zero.
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr  <= '0;
            r_rd  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_push) begin
                r_wr <= (r_wr == PTR_W'(DEPTH - 1)) ? '0 : r_wr + PTR_W'(1);
            end
            if (i_pop) begin
                r_rd <= (r_rd == PTR_W'(DEPTH - 1)) ? '0 : r_rd + PTR_W'(1);
            end
            r_cnt <= r_cnt + CNT_W'(i_push) - CNT_W'(i_pop);
        end
    end

    assign o_head  = r_mem[r_rd];
    assign o_count = r_cnt;

endmodule

// File: rtl/amber128_bundle_sequencer.sv
// Fetch-to-decode slot sequencer: buffers bundles, issues one slot op per cycle (AMBER128_SEQ_SKIP_NOP_EN drops NOPs).
// Latency: bundle accepted at edge N gives its first op valid right after N (op is combinational from head + cursor).
// Backpressure: in_ready = FIFO not full (no pop-push bypass); op held stable while out_valid && !out_ready.
module amber128_bundle_sequencer
    import amber128_pkg::*;
#(
    parameter int SLOT_COUNT = AMBER128_SLOT_COUNT,
    parameter int SLOT_W     = AMBER128_SLOT_W,
    parameter int DEPTH      = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [63:0]       in_word_addr,
    input  logic [C_XLEN-1:0] in_bundle,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [63:0]       out_pc,
    output logic [2:0]        out_slot_idx,
    output logic              out_sub12_idx,
    output logic              out_is_sub12,
    output logic [SLOT_W-1:0] out_payload,
    output logic              out_last
);

    localparam int HALF_W = SLOT_W / 2;
    localparam int NPOS   = 2 * SLOT_COUNT;
    localparam int POS_W  = 4;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int ENT_W  = 64 + C_XLEN;

    amber128_seq_state_e r_state;
    amber128_seq_state_e w_state_nxt;

    // Cursor as an op position {slot, sub}: the current op is the first issuable position >= r_pos.
    logic [POS_W-1:0]  r_pos;

    logic [CNT_W-1:0]  w_cnt;
    logic [ENT_W-1:0]  w_head;
    logic [63:0]       w_head_addr;
    logic [C_XLEN-1:0] w_head_bundle;
    logic              w_push;
    logic              w_pop;
    logic              w_fire;
    logic              w_head_ok;

    logic [SLOT_W-1:0] w_slot [8];
    logic [7:0]        w_flag;
    logic [NPOS-1:0]   w_iss;
    logic [POS_W-1:0]  w_cur;
    logic              w_any;
    logic              w_more;

    logic [2:0]        w_op_slot;
    logic              w_op_sub;
    logic              w_op_is12;
    logic [SLOT_W-1:0] w_slot_sel;
    logic [HALF_W-1:0] w_half;
    logic              w_unused;

    assign {w_head_addr, w_head_bundle} = w_head;
    // Gap bits between payload and flags and the in-bundle address nibble are never decoded.
    assign w_unused = ^{w_head_addr[3:0], w_head_bundle};

    assign in_ready = (w_cnt < CNT_W'(DEPTH));
    assign w_push   = in_valid && in_ready && !flush;

    amber128_bundle_fifo #(
        .DEPTH (DEPTH),
        .W     (ENT_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_push  (w_push),
        .i_dat   ({in_word_addr, in_bundle}),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_cnt)
    );

    // Split the head bundle into slots/flags and mark which op positions are issuable.
    always_comb begin
        w_flag = '0;
        w_iss  = '0;
        for (int i = 0; i < 8; i++) begin
            w_slot[i] = '0;
        end
        for (int i = 0; i < SLOT_COUNT; i++) begin
            w_slot[i] = w_head_bundle[i*SLOT_W +: SLOT_W];
            w_flag[i] = w_head_bundle[C_XLEN-SLOT_COUNT+i];
`ifdef AMBER128_SEQ_SKIP_NOP_EN
            if (w_flag[i]) begin
                w_iss[2*i]   = |w_slot[i][HALF_W-1:0];
                w_iss[2*i+1] = |w_slot[i][SLOT_W-1:HALF_W];
            end else begin
                w_iss[2*i]   = |w_slot[i];
            end
`else
            w_iss[2*i]   = 1'b1;
            w_iss[2*i+1] = w_flag[i];
`endif
        end
    end

    // Priority encode the current op at/after the cursor and whether any op follows it.
    always_comb begin
        w_cur  = '0;
        w_any  = 1'b0;
        w_more = 1'b0;
        for (int p = NPOS - 1; p >= 0; p--) begin
            if (w_iss[p] && (POS_W'(p) >= r_pos)) begin
                w_cur = POS_W'(p);
                w_any = 1'b1;
            end
        end
        for (int p = 0; p < NPOS; p++) begin
            if (w_iss[p] && (POS_W'(p) > w_cur)) begin
                w_more = 1'b1;
            end
        end
    end

    assign w_op_slot  = w_cur[3:1];
    assign w_op_sub   = w_cur[0];
    assign w_op_is12  = w_flag[w_op_slot];
    assign w_slot_sel = w_slot[w_op_slot];
    assign w_half     = w_op_sub ? w_slot_sel[SLOT_W-1 -: HALF_W] : w_slot_sel[HALF_W-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= SEQ_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state tracks whether the FIFO holds a head after this edge.
    always_comb begin
        w_state_nxt = r_state;
        if (flush) begin
            w_state_nxt = SEQ_EMPTY;
        end else begin
            case (r_state)
                SEQ_EMPTY: if (w_push) w_state_nxt = SEQ_ISSUE;
                SEQ_ISSUE: if (w_pop && !w_push && (w_cnt == CNT_W'(1))) w_state_nxt = SEQ_EMPTY;
                default:   w_state_nxt = SEQ_EMPTY;
            endcase
        end
    end

    // Outputs: op fields from head + cursor, zeroed while no op is offered.
    always_comb begin
        w_head_ok     = (r_state == SEQ_ISSUE);
        out_valid     = w_head_ok && w_any;
        w_fire        = out_valid && out_ready;
        // A head with nothing issuable left (all-NOP bundle) pops without offering an op.
        w_pop         = w_head_ok && ((w_fire && !w_more) || !w_any);
        out_pc        = '0;
        out_slot_idx  = '0;
        out_sub12_idx = 1'b0;
        out_is_sub12  = 1'b0;
        out_payload   = '0;
        out_last      = 1'b0;
        if (out_valid) begin
            out_pc        = {w_head_addr[63:4], 4'h0};
            out_slot_idx  = w_op_slot;
            out_sub12_idx = w_op_sub;
            out_is_sub12  = w_op_is12;
            out_payload   = w_op_is12 ? {{(SLOT_W-HALF_W){1'b0}}, w_half} : w_slot_sel;
            out_last      = !w_more;
        end
    end

    // Cursor: restart on a new head, otherwise step past the op that just fired.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_pos <= '0;
        end else if (w_pop) begin
            r_pos <= '0;
        end else if (w_fire) begin
            r_pos <= w_cur + POS_W'(1);
        end
    end

endmodule

// File: doc/amber128_bundle_sequencer.md
# amber128_bundle_sequencer

Fetch-to-decode slot sequencer for the amber128 core. Accepts 128-bit fetch bundles from IMEM, buffers them in a small FIFO and issues one slot operation per cycle to the decoder, expanding 24-bit slots flagged as dual 12-bit forms into two sequential ops. It is a parametrised generalisation of the fixed 5×24-bit bundle layout: slot count, slot width and buffer depth are configurable, and a decoder redirect can flush all buffered state.

## Interface
- SLOT_COUNT, 5, slots per bundle; flags at [C_XLEN-1 -: SLOT_COUNT], payload at [SLOT_COUNT*SLOT_W-1:0]; SLOT_COUNT*(SLOT_W+1) <= C_XLEN, SLOT_COUNT <= 8
- SLOT_W, 24, slot payload width; must be even (12-bit halves = SLOT_W/2)
- DEPTH, 2, bundle FIFO entries (>= 1)
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered bundles and the in-progress cursor
- in_valid  in  1  fetch bundle valid (amber128_fetch_s.valid)
- in_ready  out  1  FIFO can accept a bundle
- in_word_addr  in  64  bundle byte address
- in_bundle  in  C_XLEN  bundle contents
- out_valid  out  1  slot op valid
- out_ready  in  1  decoder accepts op
- out_pc  out  64  bundle address, [3:0] forced to 0
- out_slot_idx  out  3  slot index 0..SLOT_COUNT-1
- out_sub12_idx  out  1  0 = low half, 1 = high half (0 for 24-bit slots)
- out_is_sub12  out  1  op is a 12-bit form
- out_payload  out  SLOT_W  slot payload; 12-bit ops zero-extended
- out_last  out  1  op is the final issued op of its bundle

## Operation
- Slot i payload = bundle[i*SLOT_W +: SLOT_W]; flag i = bundle[C_XLEN-SLOT_COUNT+i]. Flag 1 → two 12-bit ops: [SLOT_W/2-1:0] first (sub12_idx 0), then [SLOT_W-1:SLOT_W/2].
- Push when in_valid && in_ready && !flush. in_ready = (count < DEPTH); no pop-push bypass.
- Cursor {slot, sub} over FIFO head. States: EMPTY (count 0, out_valid 0), ISSUE (head present). Op fires on out_valid && out_ready; cursor advances to next issuable op; after out_last fires, head pops and cursor resets to the first issuable op of the next entry (or EMPTY).
- out_last computed from head flags/payload: no later issuable op exists.
- flush: count, cursor, rd/wr pointers → 0 next cycle; simultaneous push and pop are discarded; out_valid is still driven that cycle but the decoder ignores it.
- Pointers wrap modulo DEPTH; count width $clog2(DEPTH+1).

## Timing
- Reset: in_ready 1, out_valid 0, all other outputs 0.
- Latency: bundle accepted at cycle N → first op valid at N+1 (registered FIFO, combinational output from head + cursor).
- Throughput: one op/cycle sustained while out_ready=1 and FIFO non-empty, including across bundle boundaries.
- out_* held stable while out_valid && !out_ready (standard valid/ready, no retraction except on flush/rst).
- Full FIFO with head's out_last firing: in_ready rises next cycle, not same cycle.

## Configuration
- AMBER128_SEQ_SKIP_NOP_EN defined: a slot with flag 0 and payload all-zero is a NOP and is not issued; a 12-bit half of all-zero is skipped likewise; a bundle with no issuable op is popped one cycle after reaching the head without asserting out_valid.
- Undefined: every slot (and both halves of flagged slots) is issued; out_last = final slot (high half if flagged).

## Structure
- amber128_pkg gains: AMBER128_SLOT_COUNT = 5, AMBER128_SLOT_W = 24, AMBER128_SUB12_W = 12, and typedef amber128_slot_op_s {valid, pc_word_addr, slot_idx, sub12_idx, is_sub12, payload, last}.
- One sub-module: amber128_bundle_fifo (parametrised DEPTH × (64+C_XLEN) sync FIFO with flush).
- Next-issuable-op priority encoder stays in the sequencer.

## Test plan
- Reset then bundle addr 0x1000, flags 0, slots 0x000001..0x000005, out_ready=1 → ops slot 0..4 at cycles N+1..N+5, out_pc 0x1000, out_last only on slot 4.
- Flag bit for slot 2 set, slot 2 = 0xABC123 → slot 2 issues 0x000123 (sub 0) then 0x000ABC (sub 1, is_sub12 1); six ops total.
- Three bundles back-to-back, DEPTH=2 → in_ready drops after two pushes, third accepted the cycle after first bundle's out_last pop; no gap in out_valid.
- out_ready held low 3 cycles mid-bundle → outputs stable, no op lost or duplicated.
- flush asserted with 2 bundles buffered and simultaneous push → next cycle out_valid 0, in_ready 1, pushed bundle absent.
- SKIP_NOP_EN: slots 1 and 3 zero → ops 0,2,4 only, out_last on 4; all-zero bundle → no out_valid, popped, next bundle issues.
